crc_checker: RTL and testbench
==============================

# crc_checker

Serial CRC-8 checker for the receive end of the team's bit-serial CRC link. It recomputes the CRC over the payload bits qualified by `Active`. It then compares that result, bit by bit, against the 8 trailing CRC bits qualified by `Valid`, and reports pass, fail or timeout with a one-cycle `DONE` pulse. It sits downstream of the serial CRC generator and uses the same polynomial, seed and bit order.

## Interface
- `SEED`, 8'hD8, LFSR value loaded at reset and at the start of every frame
- `TAPS`, 8'b01000100, feedback XOR positions (bits 6 and 2)
- `TIMEOUT`, 16, maximum consecutive idle cycles allowed while waiting for a CRC bit; must be at least 2
- `CNT_WD`, 16, width of the payload bit counter
- `CLK`  in  1  clock, rising edge
- `RST`  in  1  reset, asynchronous, active-low
- `DATA`  in  1  payload bit, sampled when `Active`=1
- `Active`  in  1  payload qualifier, one bit per cycle
- `CRC`  in  1  received CRC bit, sampled when `Valid`=1; LSB first
- `Valid`  in  1  CRC bit qualifier
- `DONE`  out  1  one-cycle frame-complete pulse
- `CRC_OK`  out  1  high with `DONE` on a full 8-bit match
- `CRC_ERR`  out  1  high with `DONE` on a mismatch, timeout or abort
- `TMO`  out  1  high with `DONE` when the frame ended by timeout
- `BUSY`  out  1  high in PAYLOAD and CRCRX
- `BIT_CNT`  out  `CNT_WD`  payload bit count of the last reported frame

## Operation
- LFSR step for bit d:
  - fb = d ^ R[0]
  - R <= (R >> 1) | (fb << 7), then XOR `TAPS` into R when fb=1
- IDLE:
  - R = `SEED`.
  - `Active`=1: step with `DATA`, cnt <= 1, go to PAYLOAD.
  - `Valid` is ignored.
- PAYLOAD:
  - `Active`=1: step, cnt++; cnt saturates at all-ones.
  - `Active`=0: go to CRCRX with idx <= 0, wait <= 0, mis <= 0.
  - If `Valid`=1 in that same cycle, that bit is also consumed as CRC bit 0.
- CRCRX, in priority order:
  - `Active`=1 (abort): report `CRC_ERR`. Restart the frame from `SEED` using the current `DATA` bit as payload bit 1, with cnt <= 1; stay BUSY in PAYLOAD.
  - `Valid`=1:
    - mis <= mis | (`CRC` ^ R[0]); R <= R >> 1; idx++; wait <= 0.
    - On the 8th bit, report `CRC_OK` = ~mis_final and `CRC_ERR` = mis_final, then go to IDLE.
  - Otherwise wait++; when wait reaches `TIMEOUT`, report `CRC_ERR` and `TMO`, then go to IDLE.
- Report:
  - `DONE` is driven for one cycle together with the flags.
  - `BIT_CNT` <= cnt.
  - `CRC_OK` and `CRC_ERR` are never high together.
- Reset (asynchronous, any state, including mid-frame):
  - State IDLE, R = `SEED`, cnt/idx/wait/mis = 0.
  - All outputs 0, including `BIT_CNT`.
  - No report is issued for a frame cut off by reset.

## Timing
- All outputs are registered.
- `DONE`/`CRC_OK`/`CRC_ERR`/`TMO` rise on the edge that samples the 8th `Valid` bit, or the timeout/abort condition, and fall on the next edge.
- `BUSY` rises on the edge that samples the first `Active`=1. It falls on the reporting edge, except for an abort, where it stays high.
- Back-to-back frames:
  - A new `Active` bit is accepted in IDLE on the cycle directly after a report.
  - A new frame may also begin on the reporting cycle via the abort path.
- Gaps:
  - Gaps inside the payload (`Active`=0) end the payload phase. Payload bits must be contiguous.
  - Gaps between CRC bits are allowed up to `TIMEOUT`-1 cycles.
- The one-cycle gap the generator leaves between its last payload bit and its first CRC bit counts as one wait cycle.

## Test plan
- Payload 0x00: 8 zeros on `DATA` with `Active`=1, 1 idle cycle, then `CRC` bits 0,0,1,0,1,0,0,0 with `Valid`=1. Required: one `DONE` pulse with `CRC_OK`=1, `CRC_ERR`=0, `BIT_CNT`=8.
- Payload 0xFF: 8 ones, then CRC 0x72 sent LSB first (0,1,0,0,1,1,1,0). Required: `CRC_OK`=1. Repeat with the CRC byte 0x73. Required: `CRC_ERR`=1, `CRC_OK`=0, `TMO`=0.
- Payload 0x00, then 3 correct CRC bits, then `Valid` low for 16 cycles. Required: `DONE` with `CRC_ERR`=1 and `TMO`=1, and no further pulse.
- Payload 0x00, 2 CRC bits, then `Active`=1 with `DATA`=1. Required: `DONE`+`CRC_ERR` (`TMO`=0) and `BUSY` stays 1. After 7 more ones and CRC 0x72, the new frame reports `CRC_OK`.
- Assert `RST` low mid-payload, after 5 bits. Required: all outputs 0 immediately and no `DONE`. A clean 0x00 frame afterwards passes.
- Stray `Valid` pulses in IDLE. Required: no `DONE` and `BUSY`=0. Two back-to-back 0x00 frames then produce two `CRC_OK` pulses.

Source files
------------

// File: rtl/crc_checker.sv
// crc_checker: serial CRC-8 receive checker; recomputes the payload CRC and
// compares it bit-serially against the trailing CRC bits.
module crc_checker #(
  parameter logic [7:0] SEED    = 8'hD8,
  parameter logic [7:0] TAPS    = 8'b01000100,
  parameter int         TIMEOUT = 16,
  parameter int         CNT_WD  = 16
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              DATA,
  input  logic              Active,
  input  logic              CRC,
  input  logic              Valid,
  output logic              DONE,
  output logic              CRC_OK,
  output logic              CRC_ERR,
  output logic              TMO,
  output logic              BUSY,
  output logic [CNT_WD-1:0] BIT_CNT
);
  localparam int WW = $clog2(TIMEOUT + 1);
  typedef enum logic [1:0] {IDLE, PAYLOAD, CRCRX} state_t;
  state_t            st;
  logic [7:0]        r;
  logic [CNT_WD-1:0] cnt;
  logic [2:0]        idx;
  logic [WW-1:0]     wt;
  logic              mis;
  logic              m;
  function automatic logic [7:0] step(input logic [7:0] v, input logic d);
    logic fb;
    fb = d ^ v[0];
    return {fb, v[7:1]} ^ (fb ? TAPS : 8'h00);
  endfunction
  assign m = mis | (CRC ^ r[0]);
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      st      <= IDLE;
      r       <= SEED;
      cnt     <= '0;
      idx     <= '0;
      wt      <= '0;
      mis     <= 1'b0;
      DONE    <= 1'b0;
      CRC_OK  <= 1'b0;
      CRC_ERR <= 1'b0;
      TMO     <= 1'b0;
      BUSY    <= 1'b0;
      BIT_CNT <= '0;
    end else begin
      DONE    <= 1'b0;
      CRC_OK  <= 1'b0;
      CRC_ERR <= 1'b0;
      TMO     <= 1'b0;
      case (st)
        IDLE: begin
          r <= SEED;
          if (Active) begin
            r    <= step(SEED, DATA);
            cnt  <= CNT_WD'(1);
            st   <= PAYLOAD;
            BUSY <= 1'b1;
          end
        end
        PAYLOAD: begin
          if (Active) begin
            r   <= step(r, DATA);
            cnt <= (&cnt) ? cnt : cnt + CNT_WD'(1);
          end else begin
            // the gap cycle before the first CRC bit already counts as waiting
            st  <= CRCRX;
            idx <= Valid ? 3'd1 : 3'd0;
            wt  <= Valid ? '0 : WW'(1);
            mis <= Valid & (CRC ^ r[0]);
            if (Valid) r <= r >> 1;
          end
        end
        default: begin
          if (Active) begin
            DONE    <= 1'b1;
            CRC_ERR <= 1'b1;
            BIT_CNT <= cnt;
            r       <= step(SEED, DATA);
            cnt     <= CNT_WD'(1);
            st      <= PAYLOAD;
          end else if (Valid) begin
            mis <= m;
            r   <= r >> 1;
            idx <= idx + 3'd1;
            wt  <= '0;
            if (idx == 3'd7) begin
              DONE    <= 1'b1;
              CRC_OK  <= ~m;
              CRC_ERR <= m;
              BIT_CNT <= cnt;
              BUSY    <= 1'b0;
              st      <= IDLE;
            end
          end else if (wt == WW'(TIMEOUT - 1)) begin
            DONE    <= 1'b1;
            CRC_ERR <= 1'b1;
            TMO     <= 1'b1;
            BIT_CNT <= cnt;
            BUSY    <= 1'b0;
            st      <= IDLE;
          end else begin
            wt <= wt + WW'(1);
          end
        end
      endcase
    end
  end
endmodule

// File: tb/tb_crc_checker.sv
// tb_crc_checker: directed frames with a scoreboard of expected reports
// popped whenever the checker pulses DONE.
module tb_crc_checker;
  logic        CLK = 1'b0;
  logic        RST = 1'b0;
  logic        DATA = 1'b0, Active = 1'b0, CRC = 1'b0, Valid = 1'b0;
  logic        DONE, CRC_OK, CRC_ERR, TMO, BUSY;
  logic [15:0] BIT_CNT;
  int          n_cmp = 0;
  int          n_err = 0;
  logic [18:0] q[$];
  crc_checker dut (
    .CLK(CLK), .RST(RST), .DATA(DATA), .Active(Active), .CRC(CRC), .Valid(Valid),
    .DONE(DONE), .CRC_OK(CRC_OK), .CRC_ERR(CRC_ERR), .TMO(TMO), .BUSY(BUSY),
    .BIT_CNT(BIT_CNT)
  );
  always #5 CLK = ~CLK;
  always @(negedge CLK) begin
    if (RST && DONE) begin
      n_cmp++;
      if (q.size() == 0) begin
        n_err++;
        $error("FAIL unexpected_done: got ok=%0b err=%0b tmo=%0b cnt=%0d want no pulse",
               CRC_OK, CRC_ERR, TMO, BIT_CNT);
      end else begin
        logic [18:0] e;
        e = q.pop_front();
        assert ({CRC_OK, CRC_ERR, TMO, BIT_CNT} === e) else begin
          n_err++;
          $error("FAIL report: got ok/err/tmo/cnt=%0b%0b%0b/%0d want %0b%0b%0b/%0d",
                 CRC_OK, CRC_ERR, TMO, BIT_CNT, e[18], e[17], e[16], e[15:0]);
        end
      end
    end
  end
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask
  task automatic tick();
    @(posedge CLK);
    #1;
  endtask
  task automatic idle(input int n);
    Active = 1'b0;
    Valid  = 1'b0;
    for (int i = 0; i < n; i++) tick();
  endtask
  task automatic send_bits(input logic [7:0] b, input int n);
    for (int i = 0; i < n; i++) begin
      Active = 1'b1;
      DATA   = b[i];
      tick();
    end
    Active = 1'b0;
    DATA   = 1'b0;
  endtask
  task automatic send_crc(input logic [7:0] c, input int n);
    for (int i = 0; i < n; i++) begin
      Valid = 1'b1;
      CRC   = c[i];
      tick();
    end
    Valid = 1'b0;
    CRC   = 1'b0;
  endtask
  task automatic expect_rep(input logic ok, input logic err, input logic tmo, input logic [15:0] cnt);
    q.push_back({ok, err, tmo, cnt});
  endtask
  initial begin
    #3;
    chk("rst_outs", {DONE, CRC_OK, CRC_ERR, TMO, BUSY}, 5'b0);
    chk("rst_bitcnt", BIT_CNT, 16'd0);
    @(posedge CLK);
    #1 RST = 1'b1;
    tick();
    expect_rep(1, 0, 0, 8);
    send_bits(8'h00, 8);
    chk("busy_payload", BUSY, 1'b1);
    idle(1);
    send_crc(8'h14, 8);
    idle(2);
    chk("busy_after_ok", BUSY, 1'b0);
    expect_rep(1, 0, 0, 8);
    send_bits(8'hFF, 8);
    idle(1);
    send_crc(8'h72, 8);
    idle(2);
    expect_rep(0, 1, 0, 8);
    send_bits(8'hFF, 8);
    idle(1);
    send_crc(8'h73, 8);
    idle(2);
    expect_rep(0, 1, 1, 8);
    send_bits(8'h00, 8);
    idle(1);
    send_crc(8'h14, 3);
    idle(15);
    chk("no_early_tmo", DONE, 1'b0);
    chk("busy_waiting", BUSY, 1'b1);
    idle(1);
    chk("tmo_done", DONE, 1'b1);
    idle(25);
    chk("busy_after_tmo", BUSY, 1'b0);
    expect_rep(0, 1, 0, 8);
    send_bits(8'h00, 8);
    idle(1);
    send_crc(8'h14, 2);
    send_bits(8'h01, 1);
    chk("abort_done", DONE, 1'b1);
    chk("abort_busy", BUSY, 1'b1);
    expect_rep(1, 0, 0, 8);
    send_bits(8'hFF, 7);
    idle(1);
    send_crc(8'h72, 8);
    idle(2);
    send_bits(8'h00, 5);
    RST = 1'b0;
    #1;
    chk("midrst_outs", {DONE, CRC_OK, CRC_ERR, TMO, BUSY}, 5'b0);
    chk("midrst_bitcnt", BIT_CNT, 16'd0);
    idle(2);
    RST = 1'b1;
    idle(20);
    expect_rep(1, 0, 0, 8);
    send_bits(8'h00, 8);
    idle(1);
    send_crc(8'h14, 8);
    idle(2);
    for (int i = 0; i < 5; i++) begin
      Valid = 1'b1;
      CRC   = 1'($urandom_range(0, 1));
      tick();
      chk("stray_busy", BUSY, 1'b0);
    end
    idle(3);
    expect_rep(1, 0, 0, 8);
    expect_rep(1, 0, 0, 8);
    send_bits(8'h00, 8);
    idle(1);
    send_crc(8'h14, 8);
    send_bits(8'h00, 8);
    idle(1);
    send_crc(8'h14, 8);
    for (int i = 0; i < 50 && q.size() != 0; i++) tick();
    chk("queue_drained", q.size(), 0);
    idle(5);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
